// File: rtl/sram_bridge_pkg.sv
// Shared types for the sram-like request/handshake bridge: size encodings,
// id-width helper and the per-channel request bundle.
package sram_bridge_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam int unsigned MAX_ADDR_W = 64;
  localparam int unsigned MAX_DATA_W = 64;
  localparam int unsigned MAX_STRB_W = MAX_DATA_W / 8;

  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Sized for the widest supported bus; narrower channels zero-extend into it.
  typedef struct packed {
    logic                  wr;
    size_e                 size;
    logic [MAX_STRB_W-1:0] wstrb;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/sram_id_fifo.sv
// Synchronous FIFO of channel ids recording the order of accepted requests.
// Push is ignored when full, pop is ignored when empty.
module sram_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// N-channel sram-like arbiter/bridge onto one memory port with in-order responses.
// Define ARB_RR_EN for round-robin arbitration; default is fixed highest-index priority.
module sram_req_arbiter
  import sram_bridge_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          ch_req,
  input  logic [NUM_CH-1:0]          ch_wr,
  input  logic [2*NUM_CH-1:0]        ch_size,
  input  logic [DATA_W/8*NUM_CH-1:0] ch_wstrb,
  input  logic [ADDR_W*NUM_CH-1:0]   ch_addr,
  input  logic [DATA_W*NUM_CH-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]          ch_addr_ok,
  output logic [NUM_CH-1:0]          ch_data_ok,
  output logic [DATA_W-1:0]          ch_rdata,
  output logic                       mem_req,
  output logic                       mem_wr,
  output logic [1:0]                 mem_size,
  output logic [DATA_W/8-1:0]        mem_wstrb,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_addr_ok,
  input  logic                       mem_data_ok,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       err_orphan
);

  localparam int unsigned ID_W   = id_width(NUM_CH);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ID_W-1:0] arb_id;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] lock_id;
  logic [ID_W-1:0] head_id;
  logic            lock_valid;
  logic            fifo_full;
  logic            fifo_empty;
  logic            handshake;
  logic            resp;
  req_t            reqs [NUM_CH];
  req_t            sel;
  logic            unused_sel;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      reqs[i] = '{
        wr:    ch_wr[i],
        size:  size_e'(ch_size[2*i +: 2]),
        wstrb: MAX_STRB_W'(ch_wstrb[STRB_W*i +: STRB_W]),
        addr:  MAX_ADDR_W'(ch_addr[ADDR_W*i +: ADDR_W]),
        wdata: MAX_DATA_W'(ch_wdata[DATA_W*i +: DATA_W])
      };
    end
  end

`ifdef ARB_RR_EN
  logic [ID_W-1:0] rr_ptr;
  int unsigned     best_dist;
  int unsigned     dist;

  // Pick the requester closest to the pointer, counting upward with wrap.
  always_comb begin
    arb_id    = '0;
    best_dist = NUM_CH;
    dist      = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      dist = (i >= 32'(rr_ptr)) ? i - 32'(rr_ptr) : i + NUM_CH - 32'(rr_ptr);
      if (ch_req[i] && dist < best_dist) begin
        best_dist = dist;
        arb_id    = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (handshake) begin
      rr_ptr <= (32'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;
    end
  end
`else
  always_comb begin
    arb_id = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_req[i]) arb_id = ID_W'(i);
    end
  end
`endif

  // A held lock is only honoured while its owner still requests.
  assign grant     = (lock_valid && ch_req[lock_id]) ? lock_id : arb_id;
  assign mem_req   = (|ch_req) && !fifo_full && !reset;
  assign handshake = mem_req && mem_addr_ok;
  assign resp      = mem_data_ok && !fifo_empty && !reset;
  assign sel       = reqs[grant];
  assign unused_sel = ^sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_valid <= 1'b0;
      lock_id    <= '0;
    end else if (handshake) begin
      lock_valid <= 1'b0;
    end else if (mem_req) begin
      lock_valid <= 1'b1;
      lock_id    <= grant;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_orphan <= 1'b0;
    end else if (mem_data_ok && fifo_empty) begin
      err_orphan <= 1'b1;
    end
  end

  always_comb begin
    mem_wr     = 1'b0;
    mem_size   = '0;
    mem_wstrb  = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    ch_addr_ok = '0;
    ch_data_ok = '0;
    ch_rdata   = '0;
    if (!reset) begin
      mem_wr    = sel.wr;
      mem_size  = sel.size;
      mem_wstrb = sel.wstrb[STRB_W-1:0];
      mem_addr  = sel.addr[ADDR_W-1:0];
      mem_wdata = sel.wdata[DATA_W-1:0];
    end
    if (handshake) ch_addr_ok[grant] = 1'b1;
    if (resp) begin
      ch_data_ok[head_id] = 1'b1;
      ch_rdata            = mem_rdata;
    end
  end

  sram_id_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (handshake),
    .pop   (resp),
    .din   (grant),
    .head  (head_id),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter (NUM_CH=2, OUTSTANDING=4); expectations
// follow ARB_RR_EN when defined.
module tb_sram_req_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  ch_req;
  logic [1:0]  ch_wr;
  logic [3:0]  ch_size;
  logic [7:0]  ch_wstrb;
  logic [63:0] ch_addr;
  logic [63:0] ch_wdata;
  logic [1:0]  ch_addr_ok;
  logic [1:0]  ch_data_ok;
  logic [31:0] ch_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic        err_orphan;

  int n_cmp = 0;
  int n_err = 0;

  sram_req_arbiter #(
    .NUM_CH      (2),
    .ADDR_W      (32),
    .DATA_W      (32),
    .OUTSTANDING (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ch_req      (ch_req),
    .ch_wr       (ch_wr),
    .ch_size     (ch_size),
    .ch_wstrb    (ch_wstrb),
    .ch_addr     (ch_addr),
    .ch_wdata    (ch_wdata),
    .ch_addr_ok  (ch_addr_ok),
    .ch_data_ok  (ch_data_ok),
    .ch_rdata    (ch_rdata),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_size    (mem_size),
    .mem_wstrb   (mem_wstrb),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata),
    .err_orphan  (err_orphan)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_in(input logic [1:0] req, input logic aok, input logic dok,
                        input logic [31:0] rd);
    ch_req      = req;
    mem_addr_ok = aok;
    mem_data_ok = dok;
    mem_rdata   = rd;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(2'b00, 1'b0, 1'b0, 32'h0);
    step();
    step();
    reset = 1'b0;
  endtask

  logic [1:0] exp_g [4];

  initial begin
    reset    = 1'b1;
    ch_wr    = 2'b10;
    ch_size  = {2'd1, 2'd2};
    ch_wstrb = {4'b0011, 4'b0000};
    ch_addr  = {32'h0000_00A1, 32'h1C00_0000};
    ch_wdata = {32'h1234_5678, 32'h0000_0000};
    set_in(2'b11, 1'b1, 1'b1, 32'h55);
    #2;
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_addr_ok", ch_addr_ok, 0);
    check_eq("rst_data_ok", ch_data_ok, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_orphan", err_orphan, 0);
    step();
    step();
    reset = 1'b0;

    // single read on channel 0
    set_in(2'b01, 1'b1, 1'b0, 32'h0);
    settle();
    check_eq("rd_mem_req", mem_req, 1);
    check_eq("rd_mem_addr", mem_addr, 32'h1C00_0000);
    check_eq("rd_mem_wr", mem_wr, 0);
    check_eq("rd_addr_ok", ch_addr_ok, 2'b01);
    check_eq("rd_no_resp", ch_data_ok, 2'b00);
    step();
    set_in(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF);
    settle();
    check_eq("rd_data_ok", ch_data_ok, 2'b01);
    check_eq("rd_rdata", ch_rdata, 32'hDEAD_BEEF);
    check_eq("rd_idle_req", mem_req, 0);
    step();

    // contention, both channels every cycle
    do_reset();
`ifdef ARB_RR_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_g = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
    for (int k = 0; k < 4; k++) begin
      set_in(2'b11, 1'b1, k > 0, 32'h100 + k);
      settle();
      check_eq($sformatf("cont_grant%0d", k), ch_addr_ok, exp_g[k]);
      if (k > 0) check_eq($sformatf("cont_resp%0d", k), ch_data_ok, exp_g[k-1]);
      step();
    end
    set_in(2'b00, 1'b0, 1'b1, 32'h0);
    settle();
    check_eq("cont_resp_last", ch_data_ok, exp_g[3]);
    step();

    // grant lock while memory stalls
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_in(2'b01, 1'b0, 1'b0, 32'h0);
      settle();
      check_eq($sformatf("lock_ch0_%0d", k), mem_addr, 32'h1C00_0000);
      step();
    end
    for (int k = 0; k < 2; k++) begin
      set_in(2'b11, 1'b0, 1'b0, 32'h0);
      settle();
      check_eq($sformatf("lock_hold%0d", k), mem_addr, 32'h1C00_0000);
      check_eq($sformatf("lock_noack%0d", k), ch_addr_ok, 2'b00);
      step();
    end
    set_in(2'b11, 1'b1, 1'b0, 32'h0);
    settle();
    check_eq("lock_hs", ch_addr_ok, 2'b01);
    check_eq("lock_hs_addr", mem_addr, 32'h1C00_0000);
    step();
    set_in(2'b11, 1'b1, 1'b1, 32'h77);
    settle();
    check_eq("unlock_grant", ch_addr_ok, 2'b10);
    check_eq("unlock_addr", mem_addr, 32'h0000_00A1);
    check_eq("unlock_resp", ch_data_ok, 2'b01);
    step();
    set_in(2'b00, 1'b0, 1'b1, 32'h0);
    settle();
    check_eq("unlock_resp2", ch_data_ok, 2'b10);
    step();

    // FIFO full behaviour
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_in(2'b01, 1'b1, 1'b0, 32'h0);
      settle();
      check_eq($sformatf("fill%0d", k), ch_addr_ok, 2'b01);
      step();
    end
    set_in(2'b01, 1'b1, 1'b0, 32'h0);
    settle();
    check_eq("full_req", mem_req, 0);
    check_eq("full_noack", ch_addr_ok, 2'b00);
    step();
    set_in(2'b01, 1'b1, 1'b1, 32'h1);
    settle();
    check_eq("full_pop_req", mem_req, 0);
    check_eq("full_pop_noack", ch_addr_ok, 2'b00);
    check_eq("full_pop_resp", ch_data_ok, 2'b01);
    step();
    set_in(2'b01, 1'b1, 1'b0, 32'h0);
    settle();
    check_eq("refill_req", mem_req, 1);
    check_eq("refill_ack", ch_addr_ok, 2'b01);
    step();
    for (int k = 0; k < 4; k++) begin
      set_in(2'b00, 1'b0, 1'b1, 32'h10 + k);
      settle();
      check_eq($sformatf("drain%0d", k), ch_data_ok, 2'b01);
      step();
    end
    set_in(2'b00, 1'b0, 1'b0, 32'h0);
    settle();
    check_eq("drain_no_orphan", err_orphan, 0);

    // response ordering 1,0,1 with write mux check
    do_reset();
    set_in(2'b10, 1'b1, 1'b0, 32'h0);
    settle();
    check_eq("ord_ack0", ch_addr_ok, 2'b10);
    check_eq("ord_wr", mem_wr, 1);
    check_eq("ord_size", mem_size, 2'd1);
    check_eq("ord_wstrb", mem_wstrb, 4'b0011);
    check_eq("ord_wdata", mem_wdata, 32'h1234_5678);
    step();
    set_in(2'b01, 1'b1, 1'b0, 32'h0);
    settle();
    check_eq("ord_ack1", ch_addr_ok, 2'b01);
    check_eq("ord_size0", mem_size, 2'd2);
    step();
    set_in(2'b10, 1'b1, 1'b0, 32'h0);
    settle();
    check_eq("ord_ack2", ch_addr_ok, 2'b10);
    step();
    set_in(2'b00, 1'b0, 1'b1, 32'hA);
    settle();
    check_eq("ord_r0", ch_data_ok, 2'b10);
    check_eq("ord_d0", ch_rdata, 32'hA);
    step();
    set_in(2'b00, 1'b0, 1'b1, 32'hB);
    settle();
    check_eq("ord_r1", ch_data_ok, 2'b01);
    check_eq("ord_d1", ch_rdata, 32'hB);
    step();
    set_in(2'b00, 1'b0, 1'b1, 32'hC);
    settle();
    check_eq("ord_r2", ch_data_ok, 2'b10);
    check_eq("ord_d2", ch_rdata, 32'hC);
    step();

    // orphan response and reset mid-flight
    set_in(2'b00, 1'b0, 1'b1, 32'hEE);
    settle();
    check_eq("orph_no_resp", ch_data_ok, 2'b00);
    check_eq("orph_rdata", ch_rdata, 32'h0);
    step();
    set_in(2'b00, 1'b0, 1'b0, 32'h0);
    settle();
    check_eq("orph_set", err_orphan, 1);
    step();
    check_eq("orph_sticky", err_orphan, 1);
    for (int k = 0; k < 2; k++) begin
      set_in(2'b01, 1'b1, 1'b0, 32'h0);
      step();
    end
    reset = 1'b1;
    set_in(2'b11, 1'b1, 1'b0, 32'h0);
    settle();
    check_eq("midrst_req", mem_req, 0);
    check_eq("midrst_ack", ch_addr_ok, 2'b00);
    check_eq("midrst_orph", err_orphan, 0);
    step();
    reset = 1'b0;
    set_in(2'b00, 1'b0, 1'b0, 32'h0);
    settle();
    check_eq("postrst_orph", err_orphan, 0);
    step();
    set_in(2'b00, 1'b0, 1'b1, 32'h99);
    settle();
    check_eq("postrst_empty", ch_data_ok, 2'b00);
    step();
    set_in(2'b00, 1'b0, 1'b0, 32'h0);
    settle();
    check_eq("postrst_orph_set", err_orphan, 1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
